// File: rtl/i2c_register_bank.sv
// Byte register file behind the I2C peripheral, with a second fabric port.
// Optional write IRQ: define I2C_REG_BANK_WRITE_IRQ_EN.
module i2c_register_bank #(
  parameter int                    NUM_REGS     = 16,
  parameter int                    READ_LATENCY = 1,
  parameter logic [NUM_REGS-1:0]   RO_MASK      = '0,
  parameter logic [NUM_REGS*8-1:0] RESET_VALUE  = '0
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_register_address,
  input  logic       i_read_enable,
  output logic [7:0] o_register_data,
  output logic       o_read_valid,
  input  logic       i_read_ack,
  input  logic [7:0] i_register_data,
  input  logic       i_write_valid,
  output logic       o_write_ack,
  input  logic [7:0] i_user_addr,
  input  logic       i_user_we,
  input  logic [7:0] i_user_wdata,
  output logic [7:0] o_user_rdata,
  output logic       o_user_collision,
  output logic       o_write_irq,
  output logic [7:0] o_irq_addr
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] LAST =
    2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    IDLE, WR_ACK, RD_WAIT, RD_VALID
  } state_t;

  state_t state, state_d;
  logic [1:0] cnt, cnt_d;
  logic rd_latch;
  logic [7:0] regs [NUM_REGS];

  logic i2c_hit, user_hit;
  logic i2c_commit, user_clash;
  logic [AW-1:0] i2c_idx, user_idx;
  logic [7:0] i2c_rbyte, user_rbyte;

  assign i2c_hit  = {24'd0, i_register_address} < 32'(NUM_REGS);
  assign user_hit = {24'd0, i_user_addr} < 32'(NUM_REGS);
  assign i2c_idx  = i_register_address[AW-1:0];
  assign user_idx = i_user_addr[AW-1:0];

  assign i2c_rbyte  = i2c_hit ? regs[i2c_idx] : 8'hFF;
  assign user_rbyte = user_hit ? regs[user_idx] : 8'hFF;

  assign i2c_commit = (state == WR_ACK) && i2c_hit
                    && !RO_MASK[i2c_idx];
  // Same-address clash: the I2C write wins, fabric write is dropped
  assign user_clash = i2c_commit && i_user_we
                    && (i_user_addr == i_register_address);

  assign o_read_valid = (state == RD_VALID);
  assign o_write_ack  = (state == WR_ACK);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    rd_latch = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_write_valid) begin
          state_d = WR_ACK;
        end else if (i_read_enable) begin
          cnt_d = '0;
          if (READ_LATENCY == 1) begin
            rd_latch = 1'b1;
            state_d  = RD_VALID;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      WR_ACK: state_d = IDLE;
      RD_WAIT: begin
        if (!i_read_enable) begin
          state_d = IDLE;
        end else if (cnt == LAST) begin
          rd_latch = 1'b1;
          state_d  = RD_VALID;
        end else begin
          cnt_d = cnt + 2'd1;
        end
      end
      RD_VALID: begin
        if (i_read_ack || !i_read_enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      o_register_data  <= '0;
      o_user_rdata     <= '0;
      o_user_collision <= 1'b0;
    end else begin
      state            <= state_d;
      cnt              <= cnt_d;
      o_user_rdata     <= user_rbyte;
      o_user_collision <= user_clash;
      if (rd_latch) o_register_data <= i2c_rbyte;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VALUE[i*8 +: 8];
    end else begin
      if (i2c_commit)
        regs[i2c_idx] <= i_register_data;
      if (i_user_we && user_hit && !user_clash)
        regs[user_idx] <= i_user_wdata;
    end
  end

`ifdef I2C_REG_BANK_WRITE_IRQ_EN
  logic       irq_q;
  logic [7:0] irq_addr_q;

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      irq_q      <= 1'b0;
      irq_addr_q <= '0;
    end else begin
      irq_q <= i2c_commit;
      if (i2c_commit) irq_addr_q <= i_register_address;
    end
  end

  assign o_write_irq = irq_q;
  assign o_irq_addr  = irq_addr_q;
`else
  assign o_write_irq = 1'b0;
  assign o_irq_addr  = 8'h00;
`endif

endmodule

// File: tb/tb_i2c_register_bank.sv
// Scoreboard bench for i2c_register_bank: I2C reads/writes,
// RO mask, unmapped space, fabric port, collisions, reset.
module tb_i2c_register_bank;

  localparam int NR  = 16;
  localparam int LAT = 2;
  localparam logic [NR-1:0]   RO = 16'h0020;
  localparam logic [NR*8-1:0] RV =
    (128'hA5 << 24) | (128'h5A << 40);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rdata;
  logic       rd_valid;
  logic       rd_ack = 1'b0;
  logic [7:0] wdata = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ack;
  logic [7:0] uaddr = '0;
  logic       uwe = 1'b0;
  logic [7:0] uwdata = '0;
  logic [7:0] urdata;
  logic       ucoll;
  logic       irq;
  logic [7:0] irq_addr;

  int total = 0;
  int bad = 0;
  logic [7:0] model [NR];
  logic [7:0] exp_q [$];

  i2c_register_bank #(
    .NUM_REGS(NR), .READ_LATENCY(LAT),
    .RO_MASK(RO), .RESET_VALUE(RV)
  ) dut (
    .i_sys_clk(clk),
    .i_rst_n(rst_n),
    .i_register_address(addr),
    .i_read_enable(rd_en),
    .o_register_data(rdata),
    .o_read_valid(rd_valid),
    .i_read_ack(rd_ack),
    .i_register_data(wdata),
    .i_write_valid(wr_valid),
    .o_write_ack(wr_ack),
    .i_user_addr(uaddr),
    .i_user_we(uwe),
    .i_user_wdata(uwdata),
    .o_user_rdata(urdata),
    .o_user_collision(ucoll),
    .o_write_irq(irq),
    .o_irq_addr(irq_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    return (a < NR) ? model[a[3:0]] : 8'hFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = RV[i*8 +: 8];
  endtask

  task automatic i2c_read(input logic [7:0] a, input string tag);
    int n;
    exp_q.push_back(model_rd(a));
    @(negedge clk);
    addr = a;
    rd_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_valid && n < 10);
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_data"}, rdata, exp_q[0]);
    @(negedge clk);
    chk({tag, "_hold"}, {rd_valid, rdata}, {1'b1, exp_q[0]});
    exp_q.delete(0);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    rd_en = 1'b0;
    chk({tag, "_vlow"}, rd_valid, 0);
  endtask

  task automatic i2c_write(input logic [7:0] a, input logic [7:0] d,
                           input string tag);
    logic ok;
    @(negedge clk);
    addr = a;
    wdata = d;
    wr_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_ack"}, wr_ack, 1);
    wr_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_ack1"}, wr_ack, 0);
    ok = (a < NR) && !RO[a[3:0]];
    if (ok) model[a[3:0]] = d;
`ifdef I2C_REG_BANK_WRITE_IRQ_EN
    chk({tag, "_irq"}, irq, ok);
    if (ok) chk({tag, "_irqa"}, irq_addr, a);
`else
    chk({tag, "_irq"}, {irq, irq_addr}, 0);
`endif
  endtask

  task automatic fab_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    uaddr = a;
    uwdata = d;
    uwe = 1'b1;
    @(negedge clk);
    uwe = 1'b0;
    if (a < NR) model[a[3:0]] = d;
    chk("fab_wr_coll", ucoll, 0);
  endtask

  task automatic fab_read(input logic [7:0] a, input string tag);
    @(negedge clk);
    uaddr = a;
    @(negedge clk);
    chk(tag, urdata, model_rd(a));
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk("rst_rv", rd_valid, 0);
    chk("rst_wa", wr_ack, 0);
    chk("rst_rd", rdata, 0);
    chk("rst_ur", urdata, 0);
    chk("rst_col", ucoll, 0);
    chk("rst_irq", {irq, irq_addr}, 0);
    rst_n = 1'b1;
    model_reset();

    i2c_read(8'h03, "rd3");
    i2c_read(8'h05, "rd5");
    i2c_write(8'h02, 8'h3C, "wr2");
    i2c_read(8'h02, "rd2");
    i2c_write(8'h05, 8'h77, "wr_ro");
    i2c_read(8'h05, "rd_ro");
    fab_write(8'h05, 8'h99);
    i2c_read(8'h05, "rd_fab5");
    i2c_read(8'hF0, "rd_unm");
    i2c_write(8'hF0, 8'h12, "wr_unm");
    fab_read(8'hF0, "fab_unm");
    fab_read(8'h02, "fab_rd2");
    i2c_write(8'h04, 8'h4D, "wr4");
    fab_read(8'h04, "fab_rd4");

    @(negedge clk);
    addr = 8'h01; wdata = 8'h11; wr_valid = 1'b1;
    @(negedge clk);
    chk("col_ack", wr_ack, 1);
    wr_valid = 1'b0;
    uaddr = 8'h01; uwdata = 8'h22; uwe = 1'b1;
    @(negedge clk);
    uwe = 1'b0;
    model[1] = 8'h11;
    chk("col_pulse", ucoll, 1);
    @(negedge clk);
    chk("col_end", ucoll, 0);
    i2c_read(8'h01, "rd_col");

    @(negedge clk);
    addr = 8'h06; wdata = 8'h66; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    uaddr = 8'h07; uwdata = 8'h77; uwe = 1'b1;
    @(negedge clk);
    uwe = 1'b0;
    model[6] = 8'h66;
    model[7] = 8'h77;
    chk("diff_col", ucoll, 0);
    i2c_read(8'h06, "rd6");
    i2c_read(8'h07, "rd7");

    @(negedge clk);
    addr = 8'h08; wdata = 8'h88;
    wr_valid = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    chk("both_ack", {wr_ack, rd_valid}, 2'b10);
    wr_valid = 1'b0; rd_en = 1'b0;
    model[8] = 8'h88;
    i2c_read(8'h08, "rd8");

    @(negedge clk);
    addr = 8'h03; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rd_valid) seen++;
    end
    chk("abandon", seen, 0);

    @(negedge clk);
    addr = 8'h03; rd_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rd_valid) seen++;
    end
    chk("rst_rdwait", seen, 0);
    i2c_read(8'h02, "rd2_rst");
    i2c_read(8'h03, "rd3_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
